// File: rtl/spi_data_io_pkg.sv
// Shared constants for the SPI download bridge: command codes and default address width.
package spi_data_io_pkg;

    localparam int ADDR_W_DEFAULT = 25;

    localparam logic [7:0] CMD_FILE_TX     = 8'h53;
    localparam logic [7:0] CMD_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;
    localparam logic [7:0] CMD_FILE_INFO   = 8'h56;

    // Payload index saturates here; every field lives below this position.
    localparam logic [2:0] PAYLOAD_IDX_MAX = 3'd7;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI slave byte receiver: synchronises SCK/SS/DI into clk27 and assembles MSB-first bytes.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk27,
    input  logic       rst_base,
    input  logic       sck,
    input  logic       ss_n,
    input  logic       di,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       first_byte
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] di_sync;
    logic                   sck_last;
    logic [2:0]             bit_cnt;
    logic [6:0]             shift;
    logic                   frame_start;
    logic                   sck_s;
    logic                   ss_s;
    logic                   di_s;

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign ss_s  = ss_sync[SYNC_STAGES-1];
    assign di_s  = di_sync[SYNC_STAGES-1];

    // DI goes through the same depth as SCK so the sampled bit lines up with the detected edge.
    always_ff @(posedge clk27 or posedge rst_base) begin
        if (rst_base) begin
            sck_sync    <= '0;
            ss_sync     <= '1;
            di_sync     <= '0;
            sck_last    <= 1'b0;
            bit_cnt     <= 3'd0;
            shift       <= 7'd0;
            frame_start <= 1'b1;
            byte_valid  <= 1'b0;
            byte_data   <= 8'd0;
            first_byte  <= 1'b0;
        end else begin
            sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck};
            ss_sync    <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            di_sync    <= {di_sync[SYNC_STAGES-2:0], di};
            sck_last   <= sck_s;
            byte_valid <= 1'b0;
            if (ss_s) begin
                bit_cnt     <= 3'd0;
                frame_start <= 1'b1;
            end else if (sck_s && !sck_last) begin
                shift   <= {shift[5:0], di_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid  <= 1'b1;
                    byte_data   <= {shift, di_s};
                    first_byte  <= frame_start;
                    frame_start <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/spi_data_io.sv
// SPI download bridge: decodes I/O-controller commands into a byte-wide ioctl write stream.
// Optional file size/extension capture is enabled with macro DATAIO_FILEINFO_EN.
module spi_data_io
    import spi_data_io_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk27,
    input  logic              rst_base,
    input  logic              SPI_SCK,
    input  logic              SPI_SS2,
    input  logic              SPI_SS4,
    input  logic              SPI_DI,
    output logic              SPI_DO,
    input  logic              clkref_n,
    output logic              ioctl_download,
    output logic [7:0]        ioctl_index,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic              ioctl_wr,
    output logic [23:0]       ioctl_fileext,
    output logic [31:0]       ioctl_filesize
);

    logic              byte_valid;
    logic              first_byte;
    logic [7:0]        byte_data;
    logic [7:0]        cmd;
    logic [2:0]        payload_idx;
    logic [ADDR_W-1:0] byte_cnt;
    logic              pending;
    logic              unused_ss4;

    assign unused_ss4 = SPI_SS4;
    assign SPI_DO     = 1'bz;

    spi_byte_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .clk27      (clk27),
        .rst_base   (rst_base),
        .sck        (SPI_SCK),
        .ss_n       (SPI_SS2),
        .di         (SPI_DI),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .first_byte (first_byte)
    );

    // Strobe is gated directly by clkref_n so it can never land outside a write slot.
    assign ioctl_wr = pending & ~clkref_n;

    always_ff @(posedge clk27 or posedge rst_base) begin
        if (rst_base) begin
            cmd            <= 8'd0;
            payload_idx    <= 3'd0;
            byte_cnt       <= '0;
            pending        <= 1'b0;
            ioctl_download <= 1'b0;
            ioctl_index    <= 8'd0;
            ioctl_addr     <= '0;
            ioctl_dout     <= 8'd0;
        end else begin
            if (ioctl_wr) pending <= 1'b0;
            if (byte_valid) begin
                if (first_byte) begin
                    cmd         <= byte_data;
                    payload_idx <= 3'd0;
                end else begin
                    if (payload_idx != PAYLOAD_IDX_MAX) payload_idx <= payload_idx + 3'd1;
                    case (cmd)
                        CMD_FILE_TX: begin
                            if (payload_idx == 3'd0) begin
                                ioctl_download <= (byte_data != 8'd0);
                                if (byte_data != 8'd0) byte_cnt <= '0;
                            end
                        end
                        CMD_FILE_TX_DAT: begin
                            if (ioctl_download) begin
                                ioctl_dout <= byte_data;
                                ioctl_addr <= byte_cnt;
                                byte_cnt   <= byte_cnt + ADDR_W'(1);
                                pending    <= 1'b1;
                            end
                        end
                        CMD_FILE_INDEX: begin
                            if (payload_idx == 3'd0) ioctl_index <= byte_data;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef DATAIO_FILEINFO_EN
    // Size arrives LSB first, extension arrives most significant character first.
    always_ff @(posedge clk27 or posedge rst_base) begin
        if (rst_base) begin
            ioctl_filesize <= 32'd0;
            ioctl_fileext  <= 24'd0;
        end else if (byte_valid && !first_byte && cmd == CMD_FILE_INFO) begin
            case (payload_idx)
                3'd0:    ioctl_filesize[7:0]   <= byte_data;
                3'd1:    ioctl_filesize[15:8]  <= byte_data;
                3'd2:    ioctl_filesize[23:16] <= byte_data;
                3'd3:    ioctl_filesize[31:24] <= byte_data;
                3'd4:    ioctl_fileext[23:16]  <= byte_data;
                3'd5:    ioctl_fileext[15:8]   <= byte_data;
                3'd6:    ioctl_fileext[7:0]    <= byte_data;
                default: ;
            endcase
        end
    end
`else
    assign ioctl_filesize = 32'd0;
    assign ioctl_fileext  = 24'd0;
`endif

endmodule

// File: tb/tb_spi_data_io.sv
// Self-checking bench for spi_data_io: directed frames plus random payloads against a frame-level model.
// Honours DATAIO_FILEINFO_EN the same way the design does.
module tb_spi_data_io;
    import spi_data_io_pkg::*;

    localparam int ADDR_W   = 25;
    localparam int SCK_HALF = 4;

    logic              clk27;
    logic              rst_base;
    logic              SPI_SCK;
    logic              SPI_SS2;
    logic              SPI_SS4;
    logic              SPI_DI;
    logic              SPI_DO;
    logic              clkref_n;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wr;
    logic [23:0]       ioctl_fileext;
    logic [31:0]       ioctl_filesize;

    int n_cmp  = 0;
    int n_fail = 0;
    int clk_mode = 0;

    logic [ADDR_W+7:0] obs_q[$];
    logic [ADDR_W+7:0] exp_q[$];
    logic [7:0]        frame[$];

    logic              m_dl;
    int unsigned       m_cnt;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_dout;
    logic [7:0]        m_index;
    logic [31:0]       m_size;
    logic [23:0]       m_ext;

    spi_data_io dut (
        .clk27          (clk27),
        .rst_base       (rst_base),
        .SPI_SCK        (SPI_SCK),
        .SPI_SS2        (SPI_SS2),
        .SPI_SS4        (SPI_SS4),
        .SPI_DI         (SPI_DI),
        .SPI_DO         (SPI_DO),
        .clkref_n       (clkref_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wr       (ioctl_wr),
        .ioctl_fileext  (ioctl_fileext),
        .ioctl_filesize (ioctl_filesize)
    );

    initial begin
        clk27 = 1'b0;
        forever #5 clk27 = ~clk27;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Write-slot driver: 0 = slot always open, 1 = toggle every 4 cycles, 2 = slot closed.
    initial begin
        int tog;
        tog = 0;
        clkref_n = 1'b0;
        forever begin
            @(posedge clk27);
            #1;
            tog = (tog + 1) % 4;
            if (clk_mode == 0) clkref_n = 1'b0;
            else if (clk_mode == 2) clkref_n = 1'b1;
            else if (tog == 0) clkref_n = ~clkref_n;
        end
    end

    // Every strobe must sit in an open slot; record what was written.
    initial begin
        forever begin
            @(negedge clk27);
            if (ioctl_wr === 1'b1) begin
                chk("wr_in_slot", {63'd0, clkref_n}, 64'd0);
                obs_q.push_back({ioctl_addr, ioctl_dout});
            end
        end
    end

    task automatic model_reset();
        m_dl = 1'b0; m_cnt = 0; m_addr = '0; m_dout = 8'd0;
        m_index = 8'd0; m_size = 32'd0; m_ext = 24'd0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic model_frame(input logic [7:0] f[$]);
        for (int i = 1; i < f.size(); i++) begin
            int k;
            k = i - 1;
            case (f[0])
                CMD_FILE_TX: if (k == 0) begin
                    m_dl = (f[i] != 8'd0);
                    if (m_dl) m_cnt = 0;
                end
                CMD_FILE_TX_DAT: if (m_dl) begin
                    exp_q.push_back({m_cnt[ADDR_W-1:0], f[i]});
                    m_addr = m_cnt[ADDR_W-1:0];
                    m_dout = f[i];
                    m_cnt  = (m_cnt + 1) % (32'd1 << ADDR_W);
                end
                CMD_FILE_INDEX: if (k == 0) m_index = f[i];
`ifdef DATAIO_FILEINFO_EN
                CMD_FILE_INFO: begin
                    if (k < 4)
                        m_size = (m_size & ~(32'hFF << (8*k))) | (32'(f[i]) << (8*k));
                    else if (k < 7)
                        m_ext = (m_ext & ~(24'hFF << (8*(6-k)))) | (24'(f[i]) << (8*(6-k)));
                end
`endif
                default: ;
            endcase
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk27);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            SPI_SCK = 1'b0;
            SPI_DI  = b[i];
            wait_clk(SCK_HALF);
            SPI_SCK = 1'b1;
            wait_clk(SCK_HALF);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] f[$]);
        SPI_SS2 = 1'b0;
        wait_clk(SCK_HALF);
        foreach (f[i]) send_bits(f[i], 8);
        SPI_SCK = 1'b0;
        wait_clk(SCK_HALF);
        SPI_SS2 = 1'b1;
        model_frame(f);
        wait_clk(20);
    endtask

    task automatic checkOutput(input string tag);
        $display("[TB] checking %s", tag);
        chk("download", {63'd0, ioctl_download}, {63'd0, m_dl});
        chk("index", {56'd0, ioctl_index}, {56'd0, m_index});
        chk("addr", 64'(ioctl_addr), 64'(m_addr));
        chk("dout", {56'd0, ioctl_dout}, {56'd0, m_dout});
        chk("filesize", {32'd0, ioctl_filesize}, {32'd0, m_size});
        chk("fileext", {40'd0, ioctl_fileext}, {40'd0, m_ext});
        chk("wr_count", 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            chk("wr_addr_data", 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_base = 1'b1;
        SPI_SCK  = 1'b0;
        SPI_SS2  = 1'b1;
        SPI_SS4  = 1'b1;
        SPI_DI   = 1'b0;
        model_reset();
        wait_clk(5);
        checkOutput("in_reset");
        rst_base = 1'b0;
        wait_clk(5);
        checkOutput("after_reset");

        frame = {CMD_FILE_TX, 8'h01};
        applyStimulus(frame);
        checkOutput("download_start");

        frame = {CMD_FILE_TX_DAT, 8'hAA, 8'hBB, 8'hCC};
        applyStimulus(frame);
        checkOutput("three_bytes");

        frame = {CMD_FILE_TX, 8'h00};
        applyStimulus(frame);
        checkOutput("download_end");

        clk_mode = 1;
        frame = {CMD_FILE_TX, 8'h01};
        applyStimulus(frame);
        frame = {CMD_FILE_TX_DAT};
        for (int i = 0; i < 6; i++) frame.push_back(8'($urandom));
        applyStimulus(frame);
        checkOutput("slot_toggle");
        clk_mode = 0;

        // A 5-bit fragment followed by SS2 high must vanish, and the next frame starts clean.
        SPI_SS2 = 1'b0;
        wait_clk(SCK_HALF);
        send_bits(CMD_FILE_TX_DAT, 8);
        send_bits(8'($urandom), 5);
        SPI_SCK = 1'b0;
        wait_clk(SCK_HALF);
        SPI_SS2 = 1'b1;
        wait_clk(20);
        checkOutput("partial_dropped");
        frame = {CMD_FILE_TX_DAT, 8'($urandom)};
        applyStimulus(frame);
        checkOutput("after_partial");

        frame = {CMD_FILE_INDEX, 8'h03};
        applyStimulus(frame);
        frame = {CMD_FILE_TX, 8'h00};
        applyStimulus(frame);
        frame = {CMD_FILE_TX_DAT, 8'h11};
        applyStimulus(frame);
        checkOutput("index_and_idle_data");

        frame = {CMD_FILE_INFO, 8'h00, 8'h10, 8'h00, 8'h00, 8'h52, 8'h4F, 8'h4D, 8'h99};
        applyStimulus(frame);
        checkOutput("file_info");

        frame = {8'h57, 8'h01, 8'h22};
        applyStimulus(frame);
        checkOutput("unknown_cmd");

        for (int r = 0; r < 4; r++) begin
            clk_mode = int'($urandom_range(0, 1));
            frame = {CMD_FILE_INDEX, 8'($urandom)};
            applyStimulus(frame);
            frame = {CMD_FILE_TX, 8'($urandom_range(1, 255))};
            applyStimulus(frame);
            frame = {CMD_FILE_TX_DAT};
            for (int i = 0; i < int'($urandom_range(1, 5)); i++) frame.push_back(8'($urandom));
            applyStimulus(frame);
            frame = {CMD_FILE_TX, 8'h00};
            applyStimulus(frame);
            checkOutput("random_download");
        end

        // Reset with a write held pending and a frame in flight.
        clk_mode = 0;
        frame = {CMD_FILE_TX, 8'h01};
        applyStimulus(frame);
        clk_mode = 2;
        frame = {CMD_FILE_TX_DAT, 8'h5A};
        applyStimulus(frame);
        SPI_SS2 = 1'b0;
        wait_clk(SCK_HALF);
        send_bits(CMD_FILE_TX_DAT, 3);
        rst_base = 1'b1;
        model_reset();
        wait_clk(3);
        checkOutput("mid_reset");
        SPI_SCK = 1'b0;
        SPI_SS2 = 1'b1;
        wait_clk(5);
        rst_base = 1'b0;
        clk_mode = 0;
        wait_clk(20);
        checkOutput("pending_cleared");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_data_io.md
Name: spi_data_io

Overview:
- SPI-slave download bridge between the MiST-style I/O controller and the core's ROM loader.
- Deserialises command and data bytes framed by SPI_SS2.
- Produces a byte-wide ioctl write stream (addr/data/strobe) in the clk27 domain.
- Feeds the SDRAM ROM-load port; the SDRAM controller is a separate block.

Parameters:
- ADDR_W, 25: width of ioctl_addr; byte counter wraps at 2^ADDR_W.
- SYNC_STAGES, 2: flip-flop synchroniser depth for SPI_SCK, SPI_SS2 and SPI_DI.

Ports:
- clk27 input 1: system clock; all logic is on its rising edge.
- rst_base input 1: reset, asynchronous, active-high.
- SPI_SCK input 1: SPI clock from the I/O controller; its frequency is at most clk27/4.
- SPI_SS2 input 1: active-low frame select for file transfers.
- SPI_SS4 input 1: ignored.
- SPI_DI input 1: serial data in, MSB first, sampled on the rising edge of SCK.
- SPI_DO output 1: always high-impedance.
- clkref_n input 1: write-slot qualifier; ioctl_wr may only assert in a cycle where it is low.
- ioctl_download output 1: download active.
- ioctl_index output 8: file index.
- ioctl_addr output ADDR_W: address of the byte presented on ioctl_dout.
- ioctl_dout output 8: download data byte.
- ioctl_wr output 1: one-cycle write strobe.
- ioctl_fileext output 24: file extension, 3 ASCII bytes.
- ioctl_filesize output 32: file size in bytes.

Behaviour:
- Reset values: ioctl_download=0, ioctl_index=0, ioctl_addr=0, ioctl_dout=0, ioctl_wr=0, ioctl_fileext=0, ioctl_filesize=0. Internal counters and the pending flag are cleared.
- Input capture:
  - SCK, SS2 and DI pass through SYNC_STAGES flops.
  - A rising edge of the synchronised SCK while synchronised SS2=0 shifts DI into an 8-bit shift register and increments a 3-bit bit counter.
  - On the 8th bit a byte is complete.
- Framing:
  - SS2 high resets the bit counter and byte-in-frame counter.
  - A partial byte is discarded.
  - The first complete byte of each frame is the command; later bytes are payload.
- Commands (package constants):
  - 0x53 FILE_TX: first payload byte non-zero → ioctl_download=1 and internal byte counter=0. Zero → ioctl_download=0. Other payload bytes are ignored.
  - 0x54 FILE_TX_DAT: each payload byte is written only if ioctl_download=1. It sets ioctl_dout=byte and ioctl_addr=counter, then counter=counter+1 mod 2^ADDR_W, and sets a pending flag. Bytes arriving while ioctl_download=0 are dropped.
  - 0x55 FILE_INDEX: first payload byte → ioctl_index.
  - 0x56 FILE_INFO: see Optional Feature.
  - Any other command: payload ignored.
- Write strobe:
  - While pending=1, ioctl_wr pulses for exactly one clk27 cycle in the first cycle with clkref_n=0, and pending clears.
  - With clkref_n tied 0, ioctl_wr asserts no later than 3 clk27 cycles after the synchronised 8th SCK edge.
  - ioctl_addr and ioctl_dout are stable while ioctl_wr=1 and until the next byte.
  - A new byte completing while pending=1 cannot occur given the SCK ratio. If it does, the new byte overwrites and a single strobe is issued.
- Download end:
  - The FILE_TX 0 frame deasserts ioctl_download in the cycle the payload byte completes.
  - ioctl_addr holds the last written address.
  - A pending write still issues.
- rst_base mid-transfer aborts everything back to reset values.

Optional Feature:
- Macro DATAIO_FILEINFO_EN.
- Defined:
  - Command 0x56 payload bytes 0..3 load ioctl_filesize LSB first.
  - Bytes 4..6 load ioctl_fileext, first byte into bits 23:16.
  - Later bytes are ignored.
- Undefined:
  - 0x56 is treated as an unknown command.
  - ioctl_fileext and ioctl_filesize are constant 0 with no registers.

Decomposition:
- Package spi_data_io_pkg holds the command constants CMD_FILE_TX=8'h53, CMD_FILE_TX_DAT=8'h54, CMD_FILE_INDEX=8'h55 and CMD_FILE_INFO=8'h56, plus the default ADDR_W.
- One sub-module, spi_byte_rx: synchroniser, edge detect, shift register and byte_valid/first_byte outputs.
- Command decode and the ioctl register stage stay in the top.

Test Plan:
- Reset then frame {0x53,0x01} → ioctl_download=1 and ioctl_addr=0, with no ioctl_wr pulse.
- Frame {0x54,0xAA,0xBB,0xCC} with clkref_n=0 → three single-cycle ioctl_wr pulses with (addr,data) = (0,AA), (1,BB), (2,CC); then frame {0x53,0x00} → ioctl_download=0 and ioctl_addr stays 2.
- clkref_n toggling every 4 clk27 cycles → each ioctl_wr occurs only while clkref_n=0; byte count is unchanged.
- SS2 raised after 5 bits of a data byte → no write; the next full frame byte is taken as a command.
- Frame {0x55,0x03} → ioctl_index=3; {0x54,0x11} sent with download inactive → no ioctl_wr.
- With DATAIO_FILEINFO_EN, frame {0x56,0x00,0x10,0x00,0x00,'R','O','M'} → ioctl_filesize=32'h1000 and ioctl_fileext=24'h524F4D. Without the macro, both outputs stay 0.
